// File: rtl/msg_decrypt_engine.sv
// Decrypts 64 parity-tagged LFSR-encrypted bytes, recovering tap pattern and seed from the space preamble.
// Optional: define MSG_PARITY_CHK_EN to count parity mismatches in err_cnt.
module msg_decrypt_engine #(
  parameter int unsigned CRYPT_BASE = 64,
  parameter int unsigned PLAIN_BASE = 0,
  parameter int unsigned MSG_LEN    = 64,
  parameter int unsigned PRE_CHECK  = 9
) (
  input  logic       clk,
  input  logic       init,
  input  logic       req,
  output logic       ack,
  output logic [7:0] mem_addr,
  output logic       mem_rd_en,
  input  logic [7:0] mem_rdata,
  output logic       mem_wr_en,
  output logic [7:0] mem_wdata,
  output logic       found,
  output logic [3:0] pt_found,
  output logic [6:0] lfsr_seed,
  output logic [6:0] err_cnt
);

  localparam logic [7:0] LP_CRYPT  = 8'(CRYPT_BASE);
  localparam logic [7:0] LP_PLAIN  = 8'(PLAIN_BASE);
  localparam logic [7:0] LP_LAST_I = 8'(MSG_LEN - 1);
  localparam logic [7:0] LP_LAST_K = 8'(PRE_CHECK);

  typedef enum logic [3:0] {
    S_IDLE, S_SEED_RD, S_SEED_WT, S_TRY_RD, S_TRY_WT,
    S_DEC_RD, S_DEC_WT, S_FAIL, S_DONE
  } state_t;

  function automatic logic [6:0] f_tap(input logic [3:0] idx);
    case (idx)
      4'd0:    return 7'h60;
      4'd1:    return 7'h48;
      4'd2:    return 7'h78;
      4'd3:    return 7'h72;
      4'd4:    return 7'h6A;
      4'd5:    return 7'h69;
      4'd6:    return 7'h5C;
      4'd7:    return 7'h7E;
      default: return 7'h7B;
    endcase
  endfunction

  function automatic logic [6:0] f_step(input logic [6:0] s, input logic [6:0] tap);
    return {s[5:0], ^(s & tap)};
  endfunction

  state_t     r_state, w_next;
  logic [7:0] r_idx;
  logic [3:0] r_pat;
  logic [6:0] r_seed;
  logic [6:0] r_lfsr;
  logic       r_found;
  logic [3:0] r_pt_found;
  logic [6:0] r_lfsr_seed;
  logic       r_req_d;

  logic [6:0] w_dec7;
  logic [6:0] w_seed_new;
  logic       w_match;
  logic       w_last_k;
  logic       w_last_i;
  logic       w_last_pat;
  logic       w_start;

  assign w_dec7     = mem_rdata[6:0] ^ r_lfsr;
  assign w_seed_new = mem_rdata[6:0] ^ 7'h20;
  assign w_match    = (w_dec7 == 7'h20);
  assign w_last_k   = (r_idx == LP_LAST_K);
  assign w_last_i   = (r_idx == LP_LAST_I);
  assign w_last_pat = (r_pat == 4'd8);
  // DONE restarts only on a fresh req edge so a held req yields a single run
  assign w_start    = ((r_state == S_IDLE) && req) ||
                      ((r_state == S_DONE) && req && !r_req_d);

  always_ff @(posedge clk) begin
    if (init) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_start) w_next = S_SEED_RD;
      S_SEED_RD: w_next = S_SEED_WT;
      S_SEED_WT: w_next = S_TRY_RD;
      S_TRY_RD:  w_next = S_TRY_WT;
      S_TRY_WT: begin
        if (w_match)         w_next = w_last_k ? S_DEC_RD : S_TRY_RD;
        else if (w_last_pat) w_next = S_FAIL;
        else                 w_next = S_TRY_RD;
      end
      S_DEC_RD:  w_next = S_DEC_WT;
      S_DEC_WT:  w_next = w_last_i ? S_DONE : S_DEC_RD;
      S_FAIL:    w_next = S_DONE;
      S_DONE:    if (w_start) w_next = S_SEED_RD;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    ack       = (r_state == S_DONE);
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (r_state)
      S_SEED_RD: begin
        mem_rd_en = 1'b1;
        mem_addr  = LP_CRYPT;
      end
      S_TRY_RD, S_DEC_RD: begin
        mem_rd_en = 1'b1;
        mem_addr  = LP_CRYPT + r_idx;
      end
      S_DEC_WT: begin
        mem_wr_en = 1'b1;
        mem_addr  = LP_PLAIN + r_idx;
        mem_wdata = {1'b0, w_dec7};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (init) begin
      r_idx       <= '0;
      r_pat       <= '0;
      r_seed      <= '0;
      r_lfsr      <= '0;
      r_found     <= 1'b0;
      r_pt_found  <= '1;
      r_lfsr_seed <= '0;
      r_req_d     <= 1'b0;
    end else begin
      r_req_d <= req;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start) begin
            r_found    <= 1'b0;
            r_pt_found <= '1;
          end
        end
        S_SEED_WT: begin
          r_seed <= w_seed_new;
          r_pat  <= '0;
          r_idx  <= 8'd1;
          r_lfsr <= f_step(w_seed_new, f_tap(4'd0));
        end
        // r_lfsr always holds the keystream value for the byte at r_idx
        S_TRY_WT: begin
          if (w_match) begin
            if (w_last_k) begin
              r_found     <= 1'b1;
              r_pt_found  <= r_pat;
              r_lfsr_seed <= r_seed;
              r_idx       <= '0;
              r_lfsr      <= r_seed;
            end else begin
              r_idx  <= r_idx + 8'd1;
              r_lfsr <= f_step(r_lfsr, f_tap(r_pat));
            end
          end else if (!w_last_pat) begin
            r_pat  <= r_pat + 4'd1;
            r_idx  <= 8'd1;
            r_lfsr <= f_step(r_seed, f_tap(r_pat + 4'd1));
          end
        end
        S_DEC_WT: begin
          r_idx  <= r_idx + 8'd1;
          r_lfsr <= f_step(r_lfsr, f_tap(r_pt_found));
        end
        default: ;
      endcase
    end
  end

`ifdef MSG_PARITY_CHK_EN
  logic [6:0] r_err_cnt;
  logic       w_par_err;

  assign w_par_err = mem_rdata[7] ^ (^mem_rdata[6:0]);

  always_ff @(posedge clk) begin
    if (init)                                   r_err_cnt <= '0;
    else if (w_start)                           r_err_cnt <= '0;
    else if ((r_state == S_DEC_WT) && w_par_err && (r_err_cnt != '1))
                                                r_err_cnt <= r_err_cnt + 7'd1;
  end

  assign err_cnt = r_err_cnt;
`else
  logic w_unused_par;
  assign w_unused_par = mem_rdata[7];
  assign err_cnt      = '0;
`endif

  assign found     = r_found;
  assign pt_found  = r_pt_found;
  assign lfsr_seed = r_lfsr_seed;

endmodule
